// File: rtl/alsu_pkg.sv
// Shared definitions for the ALSU arbiter: opcodes, command field layout,
// arbiter state encoding and the illegal-command check.
package alsu_pkg;

    localparam int CMD_W = 14;

    localparam logic [2:0] OP_AND     = 3'b000;
    localparam logic [2:0] OP_XOR     = 3'b001;
    localparam logic [2:0] OP_ADD     = 3'b010;
    localparam logic [2:0] OP_MULT    = 3'b011;
    localparam logic [2:0] OP_SHIFT   = 3'b100;
    localparam logic [2:0] OP_ROTATE  = 3'b101;
    localparam logic [2:0] OP_INVALID = 3'b110;
    localparam logic [2:0] OP_START   = 3'b111;

    localparam int OPC_MSB    = 13;
    localparam int OPC_LSB    = 11;
    localparam int A_MSB      = 10;
    localparam int A_LSB      = 8;
    localparam int B_MSB      = 7;
    localparam int B_LSB      = 5;
    localparam int CIN_BIT    = 4;
    localparam int SERIAL_BIT = 3;
    localparam int DIR_BIT    = 2;
    localparam int RED_A_BIT  = 1;
    localparam int RED_B_BIT  = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    // A command is illegal if its opcode is one the ALSU flags as invalid, or
    // if it asks for a reduction on anything other than AND/XOR.
    function automatic logic cmd_illegal(input logic [CMD_W-1:0] cmd);
        logic [2:0] opc;
        logic       red;
        opc = cmd[OPC_MSB:OPC_LSB];
        red = cmd[RED_A_BIT] | cmd[RED_B_BIT];
        return (opc == OP_INVALID) || (opc == OP_START) ||
               (red && (opc != OP_AND) && (opc != OP_XOR));
    endfunction

endpackage

// File: rtl/alsu_rr_arb2.sv
// Two-input round-robin picker. On a tie the requester that did not win last
// time is chosen; last_grant only moves when the caller strobes advance.
module alsu_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_grant_q;
    logic last_grant_d;

    // Grant selection and last-grant update.
    always_comb begin
        grant        = 2'b00;
        last_grant_d = last_grant_q;
        if (req_valid == 2'b11) begin
            grant = last_grant_q ? 2'b01 : 2'b10;
        end else begin
            grant = req_valid;
        end
        if (advance && (grant != 2'b00)) begin
            last_grant_d = grant[1];
        end
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/alsu_arbiter.sv
// Round-robin front end for a single shared ALSU. Serialises one command at a
// time, waits RESULT_LAT cycles for the result and returns it tagged with the
// requester ID. Illegal commands are answered locally with rsp_err.
// Optional build macro ALSU_ARB_PERF_EN adds saturating grant/error counters.
//
// state | meaning
// IDLE  | arbitrate, latch winning command, screen for illegal opcodes
// ISSUE | drive latched command onto alsu_cmd, start latency counter
// WAIT  | hold alsu_cmd, count to RESULT_LAT, capture alsu_out
// RESP  | present response until rsp_ready, then clear alsu_cmd
module alsu_arbiter
    import alsu_pkg::*;
#(
    parameter int RESULT_LAT = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [CMD_W-1:0] req_cmd0,
    input  logic [CMD_W-1:0] req_cmd1,
    output logic [CMD_W-1:0] alsu_cmd,
    input  logic [5:0]       alsu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [5:0]       rsp_data,
    output logic             rsp_err
`ifdef ALSU_ARB_PERF_EN
    ,
    output logic [15:0]      grant_cnt0,
    output logic [15:0]      grant_cnt1,
    output logic [7:0]       err_cnt
`endif
);

    localparam logic [3:0] LAT_CNT = 4'(RESULT_LAT);

    arb_state_e       state_q, state_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic             id_q, id_d;
    logic [CMD_W-1:0] alsu_cmd_q, alsu_cmd_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [5:0]       rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;

    logic [1:0]       grant;
    logic             advance;
    logic [CMD_W-1:0] sel_cmd;
    logic             sel_illegal;

    alsu_rr_arb2 u_rr (
        .clk       (CLK),
        .rst       (RST),
        .req_valid (req_valid),
        .advance   (advance),
        .grant     (grant)
    );

    assign sel_cmd     = grant[1] ? req_cmd1 : req_cmd0;
    assign sel_illegal = cmd_illegal(sel_cmd);

    // Next-state and output logic for the transaction sequencer.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        id_d        = id_q;
        alsu_cmd_d  = alsu_cmd_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        req_ready   = 2'b00;
        advance     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid != 2'b00) begin
                    advance   = 1'b1;
                    req_ready = grant;
                    cmd_d     = sel_cmd;
                    id_d      = grant[1];
                    if (sel_illegal) begin
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = 6'd0;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                alsu_cmd_d = cmd_q;
                cnt_d      = 4'd1;
                state_d    = WAIT;
            end
            WAIT: begin
                if (cnt_q == LAT_CNT) begin
                    rsp_data_d  = alsu_out;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    alsu_cmd_d  = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any in-flight transaction.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            id_q        <= 1'b0;
            alsu_cmd_q  <= '0;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 6'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            id_q        <= id_d;
            alsu_cmd_q  <= alsu_cmd_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign alsu_cmd  = alsu_cmd_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

`ifdef ALSU_ARB_PERF_EN
    logic [15:0] grant_cnt0_q, grant_cnt0_d;
    logic [15:0] grant_cnt1_q, grant_cnt1_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    // Saturating counters for accepted and rejected commands.
    always_comb begin
        grant_cnt0_d = grant_cnt0_q;
        grant_cnt1_d = grant_cnt1_q;
        err_cnt_d    = err_cnt_q;
        if (req_ready[0] && (grant_cnt0_q != 16'hFFFF)) begin
            grant_cnt0_d = grant_cnt0_q + 16'd1;
        end
        if (req_ready[1] && (grant_cnt1_q != 16'hFFFF)) begin
            grant_cnt1_d = grant_cnt1_q + 16'd1;
        end
        if (advance && sel_illegal && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            grant_cnt0_q <= 16'd0;
            grant_cnt1_q <= 16'd0;
            err_cnt_q    <= 8'd0;
        end else begin
            grant_cnt0_q <= grant_cnt0_d;
            grant_cnt1_q <= grant_cnt1_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign grant_cnt0 = grant_cnt0_q;
    assign grant_cnt1 = grant_cnt1_q;
    assign err_cnt    = err_cnt_q;
`endif

endmodule

// File: doc/alsu_arbiter.md
Name: alsu_arbiter

Overview:
- Two-requester round-robin controller that shares one ALSU instance and serialises command transactions onto it.
- Each transaction holds the ALSU command stable, waits a fixed result latency, captures `out`, then returns the result tagged with the requester ID.
- Illegal commands are rejected locally and never reach the ALSU, so the ALSU's invalid-state LED blink never triggers from this path.
- Sits between software or host command queues and the ALSU datapath.

Parameters:
- RESULT_LAT, 4, cycles from first driving a command to sampling alsu_out (valid range 2..15).
- CMD_W, 14, command width; fixed by the field layout below.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- req_valid  in  2  per-requester command valid
- req_ready  out  2  per-requester accept; one-hot or zero
- req_cmd0  in  14  requester 0 command
- req_cmd1  in  14  requester 1 command
- alsu_cmd  out  14  command driven to ALSU inputs, registered
- alsu_out  in  6  ALSU result
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  1  requester that owns the response
- rsp_data  out  6  captured result; 0 when rsp_err is set
- rsp_err  out  1  command rejected as illegal

Behaviour:
- Command layout: [13:11] opcode, [10:8] A, [7:5] B, [4] cin, [3] serial_in, [2] direction, [1] red_op_A, [0] red_op_B.
- ALSU bypass inputs are tied 0 at integration.
- Illegal command: opcode 3'b110 or 3'b111, or (red_op_A|red_op_B) with opcode not 3'b000/3'b001.
- Reset values: req_ready=0, alsu_cmd=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, state=IDLE, last_grant=1 (so requester 0 wins the first tie), wait counter=0.
- FSM states are IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid, grant one requester: the non-last_grant requester if both are valid, otherwise the valid one.
  - In that cycle, pulse req_ready[winner] for one cycle (a combinational function of state and req_valid), latch the command and ID, and update last_grant.
  - Go to RESP with rsp_err=1 if the command is illegal, else go to ISSUE.
- ISSUE: alsu_cmd <= latched command; counter <= 1; go to WAIT.
- WAIT:
  - alsu_cmd is held constant.
  - The counter increments each cycle.
  - When counter==RESULT_LAT, rsp_data <= alsu_out, rsp_err <= 0, and go to RESP.
- RESP:
  - rsp_valid=1, with rsp_id, rsp_data and rsp_err held stable until rsp_valid&rsp_ready.
  - On that handshake: rsp_valid <= 0, alsu_cmd <= 0, go to IDLE.
  - The next grant can occur in the cycle after the handshake.
- Only one transaction is in flight at a time.
- req_ready is never asserted outside IDLE.
- The requester must hold req_cmd stable while req_valid is high and the request is not yet accepted.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1.
- Shift/rotate depend on the ALSU's previous out. Serialisation preserves ALSU history order across requesters; no per-requester isolation is provided.
- Reset mid-transaction aborts it. No response is issued and alsu_cmd returns to 0 the next cycle.
- A req_valid deassert while not granted is legal; no request is lost.

Optional Feature:
- ALSU_ARB_PERF_EN defined:
  - Adds outputs grant_cnt0 and grant_cnt1 (16 bits each) and err_cnt (8 bits).
  - grant_cnt0/grant_cnt1 count accepted commands per requester.
  - err_cnt counts rejected commands.
  - All three saturate at all-ones and are cleared by RST.
- Undefined: those ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package alsu_pkg holds:
  - opcode constants AND/XOR/ADD/MULT/SHIFT/ROTATE/INVALID/START (3'b000..3'b111);
  - command field bit positions;
  - CMD_W;
  - state enum IDLE/ISSUE/WAIT/RESP;
  - the illegal-command check as a package function.
- One sub-module, alsu_rr_arb2: the two-input round-robin picker holding last_grant, with inputs req_valid[1:0] and an advance strobe, and output grant[1:0].

Test Plan:
- Reset, then requester 0 sends opcode 010, A=3, B=5, cin=1 with ALSU attached: req_ready[0] pulses, alsu_cmd is stable through WAIT, and the response arrives with rsp_id=0, rsp_data=9, rsp_err=0.
- Both requesters continuously valid with 6 commands each (opcode 011, A=2, B=3): grant order is 0,1,0,1,…; all responses are 6 and rsp_id alternates starting at 0.
- Requester 1 sends opcode 110: no change on alsu_cmd, response rsp_err=1, rsp_data=0, rsp_id=1; the ALSU leds stay 0.
- Opcode 010 with red_op_A=1: rejected with rsp_err=1. The same flags with opcode 000, A=7: accepted, rsp_data=1.
- rsp_ready held low for 5 cycles in RESP: rsp_valid and rsp_data stay stable, req_ready stays 0 despite req_valid=2'b11, and the grant follows the handshake.
- RST asserted during WAIT: the next cycle shows rsp_valid=0, alsu_cmd=0 and state IDLE, and requester 0 wins the next tie.
